// File: rtl/tmr_fm_pkg.sv
// Shared types and helpers for the TMR voter with fault management.
// Replica indices map in1/in2/in3 onto bit positions of the per-replica vectors.
package tmr_fm_pkg;

  typedef enum logic [1:0] {
    TMR_MODE      = 2'd0,
    DEGRADED_MODE = 2'd1,
    FAILED_MODE   = 2'd2
  } tmr_mode_e;

  localparam int unsigned REP1    = 0;
  localparam int unsigned REP2    = 1;
  localparam int unsigned REP3    = 2;
  localparam int unsigned NUM_REP = 3;

  // True when exactly one of three flags is set (odd parity, but not all three).
  function automatic logic exactly_one(input logic [2:0] v);
    return (^v) & ~(&v);
  endfunction

endpackage

// File: rtl/tmr_replica_monitor.sv
// Per-replica consecutive-mismatch counter with exclusion flag.
// at_thresh_o reports that this sample brings (or keeps) the counter at THRESH.
module tmr_replica_monitor #(
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = $clog2(THRESH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic mismatch_i,
  input  logic sample_i,
  input  logic clear_i,
  input  logic freeze_i,
  input  logic exclude_i,
  output logic at_thresh_o,
  output logic excluded_o
);

  localparam logic [CNT_W-1:0] ThreshCnt = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             excl_q, excl_d;
  logic             active;

  always_comb begin
    active  = sample_i & ~clear_i & ~freeze_i & ~excl_q;
    cnt_inc = (cnt_q == ThreshCnt) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = mismatch_i ? cnt_inc : '0;
    end
    excl_d = clear_i ? 1'b0 : (excl_q | exclude_i);
  end

  always_comb begin
    at_thresh_o = active & mismatch_i & (cnt_inc == ThreshCnt);
    excluded_o  = excl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      excl_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      excl_q <= excl_d;
    end
  end

endmodule

// File: rtl/tmr_voter_fm.sv
// Bitwise TMR voter that excludes a persistently disagreeing replica, degrades to
// duplex compare, and reports transient / persistent / uncorrectable faults.
module tmr_voter_fm
  import tmr_fm_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned THRESH  = 3,
  parameter int unsigned CNT_W   = $clog2(THRESH + 1),
  parameter int unsigned REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] vote_o,
  output logic             fault_o,
  output logic             fault_sticky_o,
  output logic [2:0]       excluded_o,
  output logic [1:0]       mode_o,
  output logic             uncorrectable_o
);

  tmr_mode_e        state_q, state_d;
  logic [WIDTH-1:0] rep [NUM_REP];
  logic [WIDTH-1:0] maj, vote_c;
  logic [2:0]       excl, at_thresh, mismatch, exclude_set;
  logic             sample, any_mm, freeze;
  logic             fault_q, fault_d, sticky_q, sticky_d, unc_q, unc_d;

  assign rep[REP1] = in1_i;
  assign rep[REP2] = in2_i;
  assign rep[REP3] = in3_i;
  assign maj       = (in1_i & in2_i) | (in1_i & in3_i) | (in2_i & in3_i);
  assign sample    = valid_i & ~clear_i;

  // The comparison scheme follows the exclusion set, so FAILED entered straight from
  // TMR keeps voting-style checks while FAILED after DEGRADED keeps the pair compare.
  always_comb begin
    mismatch = '0;
    unique case (excl)
      3'b000: begin
        for (int k = 0; k < NUM_REP; k++) begin
          mismatch[k] = (rep[k] != maj);
        end
      end
      3'b001:  mismatch = {{2{rep[REP2] != rep[REP3]}}, 1'b0};
      3'b010:  mismatch = {rep[REP1] != rep[REP3], 1'b0, rep[REP1] != rep[REP3]};
      3'b100:  mismatch = {1'b0, {2{rep[REP1] != rep[REP2]}}};
      default: mismatch = '0;
    endcase
  end

  assign freeze = (state_q == FAILED_MODE);
  // Only a clean single-replica failure in TMR is excluded; multi-replica failure
  // goes straight to FAILED with the exclusion set untouched.
  assign exclude_set = ((state_q == TMR_MODE) && exactly_one(at_thresh)) ? at_thresh : 3'b000;

  for (genvar k = 0; k < NUM_REP; k++) begin : g_mon
    tmr_replica_monitor #(
      .THRESH(THRESH),
      .CNT_W (CNT_W)
    ) u_mon (
      .clk        (clk),
      .rst        (rst),
      .mismatch_i (mismatch[k]),
      .sample_i   (valid_i),
      .clear_i    (clear_i),
      .freeze_i   (freeze),
      .exclude_i  (exclude_set[k]),
      .at_thresh_o(at_thresh[k]),
      .excluded_o (excl[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TMR_MODE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = TMR_MODE;
    end else begin
      unique case (state_q)
        TMR_MODE: begin
          if (|at_thresh) begin
            state_d = exactly_one(at_thresh) ? DEGRADED_MODE : FAILED_MODE;
          end
        end
        DEGRADED_MODE: begin
          // Pair counter is the max of the survivors: either one reaching THRESH fails.
          if (|at_thresh) begin
            state_d = FAILED_MODE;
          end
        end
        FAILED_MODE: state_d = FAILED_MODE;
        default:     state_d = TMR_MODE;
      endcase
    end
  end

  always_comb begin
    mode_o     = state_q;
    excluded_o = excl;
    vote_c     = maj;
    if (state_q != TMR_MODE) begin
      if (!excl[REP1]) begin
        vote_c = in1_i;
      end else if (!excl[REP2]) begin
        vote_c = in2_i;
      end else begin
        vote_c = in3_i;
      end
    end
  end

  always_comb begin
    any_mm   = |mismatch;
    fault_d  = sample & any_mm;
    unc_d    = sample & (((state_q == DEGRADED_MODE) & any_mm) | (state_q == FAILED_MODE));
    sticky_d = clear_i ? 1'b0 : (sticky_q | fault_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
      unc_q    <= 1'b0;
    end else begin
      fault_q  <= fault_d;
      sticky_q <= sticky_d;
      unc_q    <= unc_d;
    end
  end

  assign fault_o         = fault_q;
  assign fault_sticky_o  = sticky_q;
  assign uncorrectable_o = unc_q;

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] vote_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vote_q <= '0;
      end else begin
        vote_q <= vote_c;
      end
    end
    assign vote_o = vote_q;
  end else begin : g_comb_out
    assign vote_o = vote_c;
  end

endmodule

// File: tb/tb_tmr_voter_fm.sv
// Directed bench: combinational-output voter, registered-output voter and a THRESH=1
// voter share one stimulus stream; each check uses hand-computed expected values.
module tb_tmr_voter_fm;

  logic        clk = 1'b0;
  logic        rst, valid, clear;
  logic [31:0] in1, in2, in3;

  logic [31:0] vote0, vote1, vote_t;
  logic        fault0, fault1, fault_t;
  logic        sticky0, sticky1, sticky_t;
  logic [2:0]  excl0, excl1, excl_t;
  logic [1:0]  mode0, mode1, mode_t;
  logic        unc0, unc1, unc_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tmr_voter_fm #(.WIDTH(32), .THRESH(3), .REG_OUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in1_i(in1), .in2_i(in2), .in3_i(in3), .valid_i(valid),
    .clear_i(clear), .vote_o(vote0), .fault_o(fault0), .fault_sticky_o(sticky0),
    .excluded_o(excl0), .mode_o(mode0), .uncorrectable_o(unc0)
  );

  tmr_voter_fm #(.WIDTH(32), .THRESH(3), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in1_i(in1), .in2_i(in2), .in3_i(in3), .valid_i(valid),
    .clear_i(clear), .vote_o(vote1), .fault_o(fault1), .fault_sticky_o(sticky1),
    .excluded_o(excl1), .mode_o(mode1), .uncorrectable_o(unc1)
  );

  tmr_voter_fm #(.WIDTH(32), .THRESH(1), .REG_OUT(0)) u_dut_t1 (
    .clk(clk), .rst(rst), .in1_i(in1), .in2_i(in2), .in3_i(in3), .valid_i(valid),
    .clear_i(clear), .vote_o(vote_t), .fault_o(fault_t), .fault_sticky_o(sticky_t),
    .excluded_o(excl_t), .mode_o(mode_t), .uncorrectable_o(unc_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in1 = a;
    in2 = b;
    in3 = c;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; clear = 1'b0;
    drive(32'h0, 32'h0, 32'h0);
    #12;
    check("rst_mode", 32'(mode0), 32'd0);
    check("rst_excl", 32'(excl0), 32'd0);
    check("rst_fault", 32'(fault0), 32'd0);
    check("rst_sticky", 32'(sticky0), 32'd0);
    check("rst_unc", 32'(unc0), 32'd0);
    check("rst_vote_reg", vote1, 32'd0);
    rst = 1'b0;

    // All replicas agree
    valid = 1'b1;
    drive(32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("agree_vote", vote0, 32'h1234_5678);
      check("agree_fault", 32'(fault0), 32'd0);
      check("agree_mode", 32'(mode0), 32'd0);
    end

    // Single transient on replica 2
    in2 = 32'h1234_5679;
    #1;
    check("tr_vote", vote0, 32'h1234_5678);
    check("tr_fault_early", 32'(fault0), 32'd0);
    tick();
    check("tr_fault", 32'(fault0), 32'd1);
    check("tr_sticky", 32'(sticky0), 32'd1);
    check("tr_mode", 32'(mode0), 32'd0);
    check("t1_excl", 32'(excl_t), 32'b010);
    check("t1_mode", 32'(mode_t), 32'd1);
    in2 = 32'h1234_5678;
    tick();
    check("tr_fault_clr", 32'(fault0), 32'd0);
    check("tr_sticky_hold", 32'(sticky0), 32'd1);
    check("tr_mode2", 32'(mode0), 32'd0);
    // Two more mismatches would reach 3 only if the first had not been cleared
    in2 = 32'h1234_5679;
    tick();
    tick();
    in2 = 32'h1234_5678;
    tick();
    check("cnt_cleared_excl", 32'(excl0), 32'd0);
    check("cnt_cleared_mode", 32'(mode0), 32'd0);

    // Persistent fault on replica 3
    in3 = 32'hFFFF_0000;
    tick();
    check("p3_excl1", 32'(excl0), 32'd0);
    tick();
    check("p3_excl2", 32'(excl0), 32'd0);
    check("p3_mode2", 32'(mode0), 32'd0);
    check("p3_vote2", vote0, 32'h1234_5678);
    tick();
    check("p3_excl3", 32'(excl0), 32'b100);
    check("p3_mode3", 32'(mode0), 32'd1);
    check("p3_fault3", 32'(fault0), 32'd1);
    check("p3_unc3", 32'(unc0), 32'd0);
    in1 = 32'hA5A5_A5A5;
    in2 = 32'hA5A5_A5A5;
    #1;
    check("deg_vote", vote0, 32'hA5A5_A5A5);
    tick();
    check("deg_fault", 32'(fault0), 32'd0);
    check("deg_unc", 32'(unc0), 32'd0);
    check("deg_mode", 32'(mode0), 32'd1);

    // Duplex disagreement in DEGRADED
    in1 = 32'h1;
    in2 = 32'h2;
    tick();
    check("dup_unc1", 32'(unc0), 32'd1);
    check("dup_mode1", 32'(mode0), 32'd1);
    check("dup_fault1", 32'(fault0), 32'd1);
    check("dup_vote", vote0, 32'h1);
    tick();
    check("dup_unc2", 32'(unc0), 32'd1);
    check("dup_mode2", 32'(mode0), 32'd1);
    tick();
    check("dup_mode3", 32'(mode0), 32'd2);
    check("dup_unc3", 32'(unc0), 32'd1);
    check("dup_excl3", 32'(excl0), 32'b100);

    // valid low: status pulses drop, state holds, vote still follows inputs
    valid = 1'b0;
    in1 = 32'h77;
    tick();
    check("nv_fault", 32'(fault0), 32'd0);
    check("nv_unc", 32'(unc0), 32'd0);
    check("nv_mode", 32'(mode0), 32'd2);
    check("nv_vote", vote0, 32'h77);

    // clear together with valid and mismatch in FAILED
    valid = 1'b1;
    clear = 1'b1;
    in1 = 32'h1;
    in2 = 32'h2;
    tick();
    check("clr_mode", 32'(mode0), 32'd0);
    check("clr_excl", 32'(excl0), 32'd0);
    check("clr_sticky", 32'(sticky0), 32'd0);
    check("clr_fault", 32'(fault0), 32'd0);
    check("clr_unc", 32'(unc0), 32'd0);
    clear = 1'b0;
    drive(32'hC0FF_EE00, 32'hC0FF_EE00, 32'hC0FF_EE00);
    tick();
    check("post_clr_mode", 32'(mode0), 32'd0);
    check("post_clr_fault", 32'(fault0), 32'd0);
    check("post_clr_vote", vote0, 32'hC0FF_EE00);

    // Registered output and mid-stream reset
    drive(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();
    check("reg_vote", vote1, 32'hDEAD_BEEF);
    in3 = 32'h0;
    tick();
    check("reg_vote_maj", vote1, 32'hDEAD_BEEF);
    check("t1_excl3", 32'(excl_t), 32'b100);
    check("t1_mode3", 32'(mode_t), 32'd1);
    check("pre_rst_sticky", 32'(sticky0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vote_reg", vote1, 32'd0);
    check("mid_rst_t1_excl", 32'(excl_t), 32'd0);
    check("mid_rst_t1_mode", 32'(mode_t), 32'd0);
    check("mid_rst_sticky", 32'(sticky0), 32'd0);
    #1;
    rst = 1'b0;
    drive(32'h1357_9BDF, 32'h1357_9BDF, 32'h1357_9BDF);
    #1;
    check("reg_hold", vote1, 32'd0);
    tick();
    check("reg_latency", vote1, 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_voter_fm.md
Name: tmr_voter_fm

Overview:
- Parametrised triple-modular-redundancy voter with integrated fault management, for triplicated decode/datapath stages of the core.
- Performs bitwise majority voting on three replica words.
- Tracks persistent disagreement per replica and excludes a replica after a programmable number of consecutive mismatches, degrading to duplex compare.
- Reports transient, persistent and uncorrectable faults as registered status for the core's fault handler.

Parameters:
- WIDTH, 32, width of each replica word and of the voted output.
- THRESH, 3, consecutive mismatching valid samples before a replica is excluded (legal range 1..255).
- CNT_W, $clog2(THRESH+1), width of the per-replica consecutive-mismatch counters.
- REG_OUT, 0: 0 = vote_o is combinational (0 latency); 1 = vote_o is registered (1-cycle latency).

Ports:
- clk, in, 1, core clock.
- rst, in, 1, asynchronous active-high reset.
- in1_i, in, WIDTH, replica 1.
- in2_i, in, WIDTH, replica 2.
- in3_i, in, WIDTH, replica 3.
- valid_i, in, 1, replicas are meaningful this cycle; fault tracking only samples on valid_i.
- clear_i, in, 1, clears counters, sticky flags and exclusions; returns to TMR state.
- vote_o, out, WIDTH, voted/selected word.
- fault_o, out, 1, registered pulse: any mismatch seen in previous valid cycle.
- fault_sticky_o, out, 1, set by fault_o, held until clear_i or rst.
- excluded_o, out, 3, one bit per replica, 1 = replica excluded.
- mode_o, out, 2, 0 = TMR, 1 = DEGRADED, 2 = FAILED.
- uncorrectable_o, out, 1, registered pulse: duplex mismatch in DEGRADED, or any valid cycle in FAILED.

Behaviour:
- Reset:
  - All counters 0, excluded_o = 0, mode_o = TMR.
  - fault_o = fault_sticky_o = uncorrectable_o = 0.
  - vote_o register (REG_OUT=1) = 0.
- Voting:
  - TMR: vote = bitwise majority of in1_i/in2_i/in3_i.
  - DEGRADED: vote = lowest-indexed non-excluded replica.
  - FAILED: vote = lowest-indexed non-excluded replica. Data is passed through; it is not trusted.
- Mismatch, TMR: replica k mismatches when in_k != bitwise majority word. Two replicas may mismatch in the same cycle on different bits.
- Mismatch, DEGRADED: the two remaining replicas mismatch when they are unequal. Both counters see the mismatch.
- Counters (valid_i cycles only):
  - Non-excluded replica mismatching: counter increments, saturating at THRESH.
  - Non-excluded replica agreeing: counter clears to 0.
  - Excluded replica's counter is frozen.
- Transitions (evaluated at the clock edge of a valid_i cycle):
  - TMR -> DEGRADED when exactly one counter reaches THRESH; that replica's excluded bit is set.
  - TMR -> FAILED when two or more counters reach THRESH in the same cycle.
  - DEGRADED -> FAILED when the pair counter reaches THRESH. Pair counter = max of the two remaining counters.
  - Any state -> TMR on clear_i.
  - FAILED is otherwise terminal.
- Status timing:
  - fault_o = 1 the cycle after any valid cycle with a mismatch.
  - uncorrectable_o = 1 the cycle after a valid DEGRADED mismatch, or after any valid cycle while in FAILED.
- Simultaneous events:
  - clear_i together with valid_i: clear wins; the sample does not affect counters or status.
  - clear_i together with a mismatch: fault_o = 0 next cycle.
- Boundaries:
  - THRESH = 1: a single mismatch excludes the replica in that same edge.
  - valid_i = 0: counters and state hold; fault_o and uncorrectable_o go to 0 next cycle.
  - vote_o still follows the inputs when valid_i = 0 (it is not gated).
- Mid-operation reset: rst asynchronously forces the reset values, regardless of state.

Decomposition:
- Package tmr_fm_pkg:
  - typedef enum logic [1:0] tmr_mode_e {TMR_MODE, DEGRADED_MODE, FAILED_MODE}.
  - Replica index localparams REP1/REP2/REP3.
- Sub-module tmr_replica_monitor (parameter CNT_W, THRESH), instantiated 3x.
  - Holds the saturating consecutive-mismatch counter and the exclusion flag.
  - Inputs: mismatch, sample, clear, freeze.
  - Outputs: at_thresh, excluded.
- Top-level contains the bitwise majority, the mode FSM, the selection mux, status registers and the optional output register.

Test Plan:
- THRESH=3, REG_OUT=0, all three replicas = 32'h1234_5678 with valid_i for 10 cycles -> vote_o = 32'h1234_5678, fault_o = 0, mode_o = 0 throughout.
- in2_i = 32'h1234_5679 for 1 valid cycle, then equal again -> vote_o unchanged, fault_o pulses one cycle late, fault_sticky_o stays 1, replica 2 counter returns to 0, mode_o = 0.
- in3_i = 32'hFFFF_0000 for 3 consecutive valid cycles -> after the 3rd edge excluded_o = 3'b100 and mode_o = 1; then in1_i = in2_i = 32'hA5A5_A5A5 -> vote_o = 32'hA5A5_A5A5.
- In DEGRADED with in1_i = 32'h1, in2_i = 32'h2 for 3 valid cycles -> uncorrectable_o high from the cycle after the first mismatch; mode_o = 2 after the 3rd edge.
- In FAILED, assert clear_i together with valid_i and mismatching data -> next cycle mode_o = 0, excluded_o = 0, fault_sticky_o = 0, fault_o = 0.
- REG_OUT=1: change all replicas to 32'hDEAD_BEEF, assert rst mid-stream -> vote_o is 0 immediately on rst; after release, vote_o equals the inputs one cycle after they are applied.
